aes128_iter_core: RTL and testbench

//   Iterative AES-128 cipher core, one round per clock, selectable encrypt/decrypt per block.
//   Has on-the-fly key expansion: forward for encrypt, backward for decrypt.

---
 rtl/aes128_iter_core.sv | 169 ++++++++++++++++
 tb/tb_aes128_iter_core.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/aes128_iter_core.sv
// aes128_iter_core: iterative AES-128 encrypt/decrypt, one round per clock, on-the-fly key schedule
// (forward expansion for encrypt, backward for decrypt) with valid/ready handshakes on both sides.
module aes128_iter_core #(
  parameter int NR      = 10,
  parameter bit KEY_OUT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic [127:0] key_out,
  output logic         busy,
  output logic [3:0]   round_idx
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  localparam logic [7:0] RCON [16] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                       8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xt(x);
    end
    return p;
  endfunction
  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as AES requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = gf_inv(a);
    return i ^ rl(i, 1) ^ rl(i, 2) ^ rl(i, 3) ^ rl(i, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] isbox(input logic [7:0] a);
    return gf_inv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
  endfunction
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction
  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction
  function automatic logic [127:0] key_bwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n3 = k[31:0] ^ k[63:32];
    n2 = k[63:32] ^ k[95:64];
    n1 = k[95:64] ^ k[127:96];
    n0 = k[127:96] ^ sub_rot(n3) ^ {rc, 24'h0};
    return {n0, n1, n2, n3};
  endfunction
  // byte (r,c) sits at index r+4c; forward shift pulls from column c+r, inverse from c-r
  function automatic logic [127:0] sub_shift(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0] b;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        b = s[127 - 8 * (r + 4 * src) -: 8];
        o[127 - 8 * (r + 4 * c) -: 8] = inv ? isbox(b) : sbox(b);
      end
    end
    return o;
  endfunction
  function automatic logic [31:0] mix_col(input logic [31:0] w, input logic inv);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return inv ?
      {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
       gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
       gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
       gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)} :
      {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
       a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
       a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
       xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction
  function automatic logic [127:0] mix_all(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127 - 32 * c -: 32] = mix_col(s[127 - 32 * c -: 32], inv);
    return o;
  endfunction
  state_t       state_q, state_d;
  logic [127:0] st_q, st_d, rk_q, rk_d, dout_q, dout_d, kout_q, kout_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         mode_q, mode_d;
  logic         last, accept, step;
  logic [127:0] kf, kb, nk, sb, ak, mx, res;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      dout_q  <= '0;
      kout_q  <= '0;
      rnd_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      dout_q  <= dout_d;
      kout_q  <= kout_d;
      rnd_q   <= rnd_d;
      mode_q  <= mode_d;
    end
  end
  // decrypt adds the round key before InvMixColumns; encrypt adds it after MixColumns
  always_comb begin
    last = rnd_q == 4'(NR);
    kf   = key_fwd(rk_q, RCON[rnd_q]);
    kb   = key_bwd(rk_q, RCON[4'(NR + 1) - rnd_q]);
    nk   = mode_q ? kb : kf;
    sb   = sub_shift(st_q, mode_q);
    ak   = mode_q ? sb ^ kb : sb;
    mx   = mix_all(ak, mode_q);
    res  = mode_q ? (last ? ak : mx) : (last ? ak : mx) ^ kf;
  end
  always_comb begin
    accept  = state_q == IDLE && in_valid;
    step    = state_q == ROUND;
    state_d = state_q == IDLE ? (in_valid ? ROUND : IDLE) :
              state_q == ROUND ? (last ? DONE : ROUND) :
              (out_ready ? IDLE : DONE);
    st_d    = accept ? data_in ^ key_in : step ? res : st_q;
    rk_d    = accept ? key_in : step ? nk : rk_q;
    mode_d  = accept ? mode : mode_q;
    rnd_d   = accept ? 4'd1 : step ? (last ? 4'd0 : rnd_q + 4'd1) : rnd_q;
    dout_d  = step && last ? res : dout_q;
    kout_d  = step && last ? nk : kout_q;
  end
  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == DONE;
    busy      = state_q != IDLE;
  end
  assign data_out  = dout_q;
  assign key_out   = KEY_OUT ? kout_q : '0;
  assign round_idx = rnd_q;
endmodule

// File: tb/tb_aes128_iter_core.sv
// tb_aes128_iter_core: directed AES-128 vectors for encrypt, decrypt, backpressure, abort and reduced rounds.
module tb_aes128_iter_core;
  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY2 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K0_2 = 128'h000102030405060708090a0b0c0d0e0f;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, mode, out_valid, out_ready, busy;
  logic [127:0] data_in, key_in, data_out, key_out;
  logic [3:0] round_idx;
  logic in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [127:0] data_out1, key_out1;
  logic [3:0] round_idx1;
  int checks = 0;
  int errors = 0;
  logic [127:0] held, ko;
  int n;
  always #5 clk = ~clk;
  aes128_iter_core u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .data_in(data_in), .key_in(key_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .key_out(key_out), .busy(busy), .round_idx(round_idx)
  );
  aes128_iter_core #(.NR(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .mode(1'b0),
    .data_in(128'h0), .key_in(128'h0), .out_valid(out_valid1), .out_ready(out_ready1),
    .data_out(data_out1), .key_out(key_out1), .busy(busy1), .round_idx(round_idx1)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // called at a negedge with the core idle; returns at the negedge where out_valid is seen
  task automatic run(input logic m, input logic [127:0] d, input logic [127:0] k, input bit tog,
                     input string tag);
    int cnt;
    chk({tag, " in_ready"}, 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    mode = m;
    data_in = d;
    key_in = k;
    @(negedge clk);
    in_valid = 1'b0;
    if (tog) begin
      mode = ~m;
      data_in = ~d;
      key_in = ~k;
    end
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk({tag, " latency"}, 128'(cnt), 128'(10));
  endtask
  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " idle in_ready"}, 128'(in_ready), 128'(1));
    chk({tag, " idle out_valid"}, 128'(out_valid), 128'(0));
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    mode = 1'b0;
    data_in = '0;
    key_in = '0;
    out_ready = 1'b0;
    in_valid1 = 1'b0;
    out_ready1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst in_ready", 128'(in_ready), 128'(1));
    chk("rst out_valid", 128'(out_valid), 128'(0));
    chk("rst busy", 128'(busy), 128'(0));
    chk("rst round_idx", 128'(round_idx), 128'(0));
    chk("rst data_out", data_out, 128'h0);
    chk("rst key_out", key_out, 128'h0);
    rst = 1'b0;
    @(negedge clk);
    run(1'b0, PT1, KEY1, 1'b0, "t1");
    chk("t1 data_out", data_out, CT1);
    chk("t1 key_out", key_out, K10);
    chk("t1 busy", 128'(busy), 128'(1));
    chk("t1 round_idx", 128'(round_idx), 128'(0));
    release_out("t1");
    run(1'b1, CT2, KEY2, 1'b0, "t2");
    chk("t2 data_out", data_out, PT2);
    chk("t2 key_out", key_out, K0_2);
    held = data_out;
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      data_in = {4{$urandom}};
      @(negedge clk);
      chk("t3 data_out stable", data_out, held);
      chk("t3 in_ready", 128'(in_ready), 128'(0));
      chk("t3 out_valid", 128'(out_valid), 128'(1));
    end
    in_valid = 1'b0;
    release_out("t3");
    chk("t4 in_ready", 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    mode = 1'b0;
    data_in = PT1;
    key_in = KEY1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (round_idx != 4'd5 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t4 reached round 5", 128'(round_idx), 128'(5));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4 out_valid", 128'(out_valid), 128'(0));
    chk("t4 busy", 128'(busy), 128'(0));
    chk("t4 round_idx", 128'(round_idx), 128'(0));
    chk("t4 data_out", data_out, 128'h0);
    chk("t4 key_out", key_out, 128'h0);
    @(negedge clk);
    run(1'b0, PT1, KEY1, 1'b0, "t4 rerun");
    chk("t4 rerun data_out", data_out, CT1);
    release_out("t4");
    run(1'b0, PT1, KEY1, 1'b1, "t5 enc");
    chk("t5 enc data_out", data_out, CT1);
    ko = key_out;
    release_out("t5 enc");
    run(1'b1, CT1, ko, 1'b0, "t5 dec");
    chk("t5 dec data_out", data_out, PT1);
    chk("t5 dec key_out", key_out, KEY1);
    release_out("t5 dec");
    chk("t6 in_ready", 128'(in_ready1), 128'(1));
    in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    chk("t6 round_idx", 128'(round_idx1), 128'(1));
    chk("t6 out_valid early", 128'(out_valid1), 128'(0));
    @(negedge clk);
    chk("t6 out_valid", 128'(out_valid1), 128'(1));
    chk("t6 data_out", data_out1, 128'h01000000010000000100000001000000);
    chk("t6 key_out", key_out1, 128'h62636363626363636263636362636363);
    out_ready1 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    chk("t6 idle", 128'(in_ready1), 128'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
